// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and word geometry for the LSU
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {IDLE, LD, RMW_RD, ST, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if: core request/response and word-memory signals of the LSU
interface lsu_mem_master_if #(parameter int AW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte/half lane extract-with-extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  logic [31:0] ins;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'd0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'd0, h} : word;
    mask = funct3 == F3_B ? 32'h0000_00FF << {lane, 3'b000} : (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF);
    ins  = funct3 == F3_B ? {24'd0, wdata[7:0]} << {lane, 3'b000} : {2{wdata}};
    merged = (word & ~mask) | (ins & mask);
  end
endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: RV32I load/store initiator over a word-only memory (sub-word via RMW).
// Define LSU_ERR_COUNT_EN to add a saturating 16-bit err_count output.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW = 32
) (
  input logic clk,
  input logic rst,
  lsu_mem_master_if.master bus
`ifdef LSU_ERR_COUNT_EN
  , output logic [15:0] err_count
`endif
);
  lsu_state_t    state;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic [15:0]   wdata_q;
  logic [31:0]   load_data;
  logic [31:0]   merged;
  logic [AW-1:0] idx;
  logic          half;
  logic          err;
  logic          word_st;
  always_comb begin
    idx = bus.req_addr >> $clog2(WORD_BYTES);
    half = bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU;
    word_st = bus.req_we && bus.req_funct3 == F3_W;
    err = (half && bus.req_addr[0]) ||
          (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00) ||
          idx >= AW'(DEPTH_WORDS) ||
          (bus.req_we ? bus.req_funct3 > F3_W : bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
  end
  lsu_lane_align u_align (
    .word(bus.mem_rdata),
    .lane(lane_q),
    .funct3(f3_q),
    .wdata(wdata_q),
    .load_data(load_data),
    .merged(merged)
  );
  // Only the low half of the store data is needed after accept; word stores go straight to mem_wdata.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      lane_q <= '0;
      wdata_q <= '0;
      bus.req_ready <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q <= bus.req_we;
          f3_q <= bus.req_funct3;
          lane_q <= bus.req_addr[1:0];
          wdata_q <= bus.req_wdata[15:0];
          bus.req_ready <= 1'b0;
          bus.resp_err <= err;
          bus.resp_valid <= err;
          bus.resp_rdata <= '0;
          bus.mem_addr <= 32'(idx);
          bus.mem_wdata <= bus.req_wdata;
          bus.mem_read <= !err && !word_st;
          bus.mem_write <= !err && word_st;
          state <= err ? RESP : !bus.req_we ? LD : word_st ? ST : RMW_RD;
        end
        LD, RMW_RD: begin
          bus.mem_read <= 1'b0;
          bus.mem_write <= we_q;
          bus.mem_wdata <= we_q ? merged : bus.mem_wdata;
          bus.resp_rdata <= we_q ? '0 : load_data;
          bus.resp_valid <= !we_q;
          state <= we_q ? ST : RESP;
        end
        ST: begin
          bus.mem_write <= 1'b0;
          bus.resp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err <= 1'b0;
          bus.resp_rdata <= '0;
          bus.req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef LSU_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (state == RESP && bus.resp_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed self-checking bench for lsu_mem_master with a word memory model
module tb_lsu_mem_master;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int overlap = 0;
  int ready_resp = 0;
  logic [31:0] mem [64];
  lsu_mem_master_if #(.AW(32)) bus ();
`ifdef LSU_ERR_COUNT_EN
  logic [15:0] err_count;
  lsu_mem_master #(.DEPTH_WORDS(64), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus), .err_count(err_count));
`else
  lsu_mem_master #(.DEPTH_WORDS(64), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
  always @(posedge clk) if (!rst && bus.req_valid && bus.req_ready) accepts++;
  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) overlap++;
    if (bus.req_ready && bus.resp_valid) ready_resp++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
  endtask
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output int nrd, output int nwr,
                      output logic [31:0] rd, output logic [31:0] wdo, output logic [31:0] ma, output logic err);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    drive(we, f3, addr, wd);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    ma = bus.mem_addr;
    lat = 0; nrd = 0; nwr = 0; rd = '0; wdo = '0; err = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.mem_read) nrd++;
      if (bus.mem_write) begin
        nwr++;
        wdo = bus.mem_wdata;
      end
      if (bus.resp_valid) begin
        rd = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
    end
    if (!bus.resp_valid) check("resp_timeout", 32'(bus.resp_valid), 32'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, nrd, nwr, got, a0;
    logic [31:0] rd, wdo, ma;
    logic err;
    logic [31:0] b2b_exp [3];
    b2b_exp[0] = 32'h0;
    b2b_exp[1] = 32'h1122_3344;
    b2b_exp[2] = 32'h0000_0033;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[63] = 32'h0BAD_F00D;
    bus.req_valid = 1'b0;
    drive(1'b0, F3_W, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_strobes", {28'd0, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    xact(1'b1, F3_W, 32'h20, 32'hDEAD_BEEF, lat, nrd, nwr, rd, wdo, ma, err);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_rw", {16'(nrd), 16'(nwr)}, {16'd0, 16'd1});
    check("sw_wdata", wdo, 32'hDEAD_BEEF);
    check("sw_addr", ma, 32'd8);
    check("sw_rdata", rd, 32'd0);
    check("sw_mem", mem[8], 32'hDEAD_BEEF);
    xact(1'b0, F3_W, 32'h20, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rw", {16'(nrd), 16'(nwr)}, {16'd1, 16'd0});
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_addr", ma, 32'd8);
    xact(1'b1, F3_B, 32'h21, 32'hFFFF_FF5A, lat, nrd, nwr, rd, wdo, ma, err);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_rw", {16'(nrd), 16'(nwr)}, {16'd1, 16'd1});
    check("sb_wdata", wdo, 32'hDEAD_5AEF);
    check("sb_mem", mem[8], 32'hDEAD_5AEF);
    xact(1'b0, F3_B, 32'h23, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lb", rd, 32'hFFFF_FFDE);
    xact(1'b0, F3_BU, 32'h23, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lbu", rd, 32'h0000_00DE);
    xact(1'b0, F3_H, 32'h22, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lh", rd, 32'hFFFF_DEAD);
    xact(1'b0, F3_HU, 32'h20, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lhu", rd, 32'h0000_5AEF);
    xact(1'b1, F3_H, 32'h22, 32'hABCD_8001, lat, nrd, nwr, rd, wdo, ma, err);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_wdata", wdo, 32'h8001_5AEF);
    xact(1'b0, F3_H, 32'h22, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lh_after_sh", rd, 32'hFFFF_8001);
    xact(1'b0, F3_W, 32'hFC, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("lw_last_word", {rd[30:0], err}, {31'h0BAD_F00D, 1'b0});
    xact(1'b0, F3_W, 32'h22, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("err_misalign_lat", 32'(lat), 32'd1);
    check("err_misalign", {rd[30:0], err}, {31'd0, 1'b1});
    check("err_misalign_rw", {16'(nrd), 16'(nwr)}, 32'd0);
    xact(1'b1, F3_H, 32'h101, 32'h1234, lat, nrd, nwr, rd, wdo, ma, err);
    check("err_sh_odd", {15'(nrd), 16'(nwr), err}, {31'd0, 1'b1});
    xact(1'b0, F3_W, 32'h100, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("err_range", {15'(nrd), 16'(nwr), err}, {31'd0, 1'b1});
    xact(1'b0, 3'b011, 32'h20, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("err_f3", {15'(nrd), 16'(nwr), err}, {31'd0, 1'b1});
    check("err_mem_intact", mem[8], 32'h8001_5AEF);
`ifdef LSU_ERR_COUNT_EN
    check("err_count", 32'(err_count), 32'd4);
`endif
    a0 = accepts;
    got = 0;
    @(negedge clk);
    drive(1'b1, F3_W, 32'h40, 32'h1122_3344);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 30 && got < 3; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        check($sformatf("b2b_rdata%0d", got), bus.resp_rdata, b2b_exp[got]);
        got++;
        if (got == 1) drive(1'b0, F3_W, 32'h40, 32'h0);
        else if (got == 2) drive(1'b0, F3_BU, 32'h41, 32'h0);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_resps", 32'(got), 32'd3);
    check("b2b_accepts", 32'(accepts - a0), 32'd3);
    xact(1'b1, F3_W, 32'h10, 32'hCAFE_F00D, lat, nrd, nwr, rd, wdo, ma, err);
    @(negedge clk);
    drive(1'b1, F3_B, 32'h10, 32'h77);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check("rmw_rd_active", 32'(bus.mem_read), 32'd1);
    #1 rst = 1'b1;
    #1 check("mid_rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_mem", mem[4], 32'hCAFE_F00D);
    xact(1'b0, F3_W, 32'h10, 32'h0, lat, nrd, nwr, rd, wdo, ma, err);
    check("mid_rst_lw", rd, 32'hCAFE_F00D);
    check("strobe_overlap", 32'(overlap), 32'd0);
    check("ready_with_resp", 32'(ready_resp), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the single-cycle core's memory stage and the word-addressed data memory.
- Accepts one byte-addressed RV32I load or store per handshake and drives the memory's MemRead/MemWrite/address/write_data side.
- Implements byte and halfword accesses over the word-only memory: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores.
- Detects misaligned, out-of-range and illegal-funct3 requests and returns an error instead of touching memory.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the target memory; word index >= DEPTH_WORDS is out of range.
AW, 32, byte-address width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  core request valid
req_ready  output  1  LSU can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  AW  byte address
req_wdata  input  32  store data, LSB-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  request rejected, no memory access
mem_read  output  1  to memory MemRead
mem_write  output  1  to memory MemWrite
mem_addr  output  32  word index = req_addr >> 2
mem_wdata  output  32  to memory write_data
mem_rdata  input  32  from memory read_data, combinational

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0; all latched request fields=0.
- FSM states: IDLE, LD, RMW_RD, ST, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr and wdata.
  - Route by request type:
    - error -> RESP
    - load -> LD
    - store of B or H -> RMW_RD
    - store of W -> ST
- LD: mem_read=1 for exactly one cycle; the addressed lane is extracted, extended and registered; next state RESP.
- RMW_RD:
  - mem_read=1; the full word is captured.
  - The byte or half lane of the captured word is replaced with wdata[7:0] or wdata[15:0]; all other bytes are preserved.
  - Next state ST.
- ST: mem_write=1 and mem_wdata = merged word (RMW) or wdata (W) for exactly one cycle; the memory writes on that edge; next state RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- req_ready=0 in every state except IDLE, so a new request cannot be accepted in the same cycle as resp_valid.
- Latency from the accept edge to resp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- mem_read and mem_write are never asserted together. Both are 0 in IDLE and RESP.
- mem_addr is held at the latched word index while busy.
- Lane selection by addr[1:0]:
  - byte: lane = addr[1:0]
  - half: lane = addr[1]
- Load extension:
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes through.
- Error conditions, each giving resp_err=1 and resp_rdata=0 with no mem_read/mem_write:
  - H/HU with addr[0]=1
  - W with addr[1:0]!=0
  - (addr>>2) >= DEPTH_WORDS
  - load funct3 in {011,110,111}
  - store funct3 > 010
- Reset mid-operation:
  - All strobes drop immediately; state returns to IDLE.
  - An RMW store in progress is abandoned. If reset occurs before ST, the memory is unchanged.

Optional Feature:
- LSU_ERR_COUNT_EN defined:
  - Adds output err_count (16 bits), reset to 0.
  - Increments on every RESP cycle with resp_err=1 and saturates at 16'hFFFF.
- LSU_ERR_COUNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_t
  - constant WORD_BYTES=4
- One combinational sub-module, lsu_lane_align, holds the byte/half extract-with-extend and merge-into-word logic; it is reused by the LD and RMW_RD paths.

Test Plan:
- Reset holds IDLE: release rst -> req_ready=1, all other outputs 0. Assert rst during RMW_RD of sb to 0x10 -> memory word 4 unchanged; FSM back in IDLE.
- Word store then load: sw 0xDEADBEEF @0x20; lw @0x20 -> resp_rdata=0xDEADBEEF; store resp 2 cycles after accept; load resp 2 cycles after accept; mem_addr=8.
- Byte RMW: word 8=0xDEADBEEF, sb 0x5A @0x21 -> exactly one mem_read cycle then one mem_write cycle with mem_wdata=0xDEAD5AEF; resp 3 cycles after accept.
- Load extension: word 8=0xDEAD5AEF:
  - lb @0x23 -> 0xFFFFFFDE
  - lbu @0x23 -> 0x000000DE
  - lh @0x22 -> 0xFFFFDEAD
  - lhu @0x20 -> 0x00005AEF
- Errors:
  - lw @0x22 -> resp_err=1, resp_rdata=0, 1-cycle latency, no mem strobes
  - sh @0x101 -> resp_err=1
  - lw @0x100 (index 64) -> resp_err=1
  - load funct3=011 -> resp_err=1
  - with LSU_ERR_COUNT_EN, err_count=4 after these four requests
- Back-to-back: req_valid held high for 3 requests -> each accepted only when req_ready=1 in IDLE; no overlap of resp_valid with accept; mem_read and mem_write never both high.
